// File: rtl/rv_regfile_sb_if.sv
// Register-file bus: read ports, writeback port and scoreboard allocation.
//   rs_addr    : NRD packed 5-bit read addresses (port k at [5k+4:5k])
//   rs_data    : NRD packed XLEN-bit read data
//   rs_busy    : per-port pending-write flag
//   rs_illegal : per-port out-of-range address flag
//   wb_we/wb_addr/wb_data : writeback (also releases busy)
//   alloc_en/alloc_addr   : destination reservation from issue
//   alloc_ok   : reservation would be accepted this cycle
//   any_busy   : at least one register has a pending write
// master = issue/writeback side, slave = register file.
interface rv_regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NRD  = 2
);
  logic [5*NRD-1:0]    rs_addr;
  logic [XLEN*NRD-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic [NRD-1:0]      rs_illegal;
  logic                wb_we;
  logic [4:0]          wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                alloc_en;
  logic [4:0]          alloc_addr;
  logic                alloc_ok;
  logic                any_busy;

  modport master (
    output rs_addr, wb_we, wb_addr, wb_data, alloc_en, alloc_addr,
    input  rs_data, rs_busy, rs_illegal, alloc_ok, any_busy
  );

  modport slave (
    input  rs_addr, wb_we, wb_addr, wb_data, alloc_en, alloc_addr,
    output rs_data, rs_busy, rs_illegal, alloc_ok, any_busy
  );
endinterface

// File: rtl/rv_regfile_sb.sv
// Integer register file with write-to-read bypass and per-register busy
// scoreboard for RAW hazard detection.
//   sys_clk   : clock, all state changes on rising edge
//   sys_reset : synchronous active-low reset
//   bus       : rv_regfile_sb_if slave (reads, writeback, allocation)
// x0 reads zero, ignores writes and is never busy. Addresses >= NREGS
// read as zero/illegal and are ignored for writes and allocation.
module rv_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic          sys_clk,
  input logic          sys_reset,
  rv_regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} busy_e;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  busy_e           busy_q [NREGS];
  busy_e           busy_d [NREGS];

  logic [XLEN*NRD-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NRD-1:0]      rd_ill;
  logic                wb_fire;
  logic                alloc_ok;
  logic                any_busy;
  logic [4:0]          ra;

  function automatic logic legal(input logic [4:0] a);
    return int'(a) < NREGS;
  endfunction

  // Write that actually lands this cycle; masked by reset so reads stay
  // zero while reset is held.
  assign wb_fire = sys_reset && bus.wb_we && legal(bus.wb_addr) &&
                   (bus.wb_addr != 5'd0);

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_ill  = '0;
    ra      = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = bus.rs_addr[5*k +: 5];
      rd_ill[k] = !legal(ra);
      if (legal(ra) && ra != 5'd0) begin
        if (BYPASS != 0 && wb_fire && ra == bus.wb_addr) begin
          rd_data[XLEN*k +: XLEN] = bus.wb_data;
          rd_busy[k]              = 1'b0;
        end else begin
          rd_data[XLEN*k +: XLEN] = regs_q[ra[AW-1:0]];
          rd_busy[k]              = (busy_q[ra[AW-1:0]] == BUSY);
        end
      end
    end
  end

  // With bypass, a same-cycle writeback to the target frees it for the
  // new allocation; without bypass only the stored busy bit counts.
  always_comb begin
    alloc_ok = 1'b0;
    if (legal(bus.alloc_addr)) begin
      if (bus.alloc_addr == 5'd0) begin
        alloc_ok = 1'b1;
      end else begin
        alloc_ok = (busy_q[bus.alloc_addr[AW-1:0]] == IDLE) ||
                   (BYPASS != 0 && wb_fire && bus.wb_addr == bus.alloc_addr);
      end
    end
  end

  always_comb begin
    any_busy = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (busy_q[r] == BUSY) any_busy = 1'b1;
    end
  end

  // Allocation is applied after the writeback release so a same-register
  // wb+alloc leaves the register busy for the new producer.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (!sys_reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_d[r] = '0;
        busy_d[r] = IDLE;
      end
    end else begin
      if (wb_fire) begin
        regs_d[bus.wb_addr[AW-1:0]] = bus.wb_data;
        busy_d[bus.wb_addr[AW-1:0]] = IDLE;
      end
      if (bus.alloc_en && alloc_ok && bus.alloc_addr != 5'd0) begin
        busy_d[bus.alloc_addr[AW-1:0]] = BUSY;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
  end

  assign bus.rs_data    = rd_data;
  assign bus.rs_busy    = rd_busy;
  assign bus.rs_illegal = rd_ill;
  assign bus.alloc_ok   = alloc_ok;
  assign bus.any_busy   = any_busy;

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Bench for rv_regfile_sb: four configurations share one stimulus stream.
//   inst0: XLEN32 NREGS32 NRD2 BYPASS1   inst1: XLEN32 NREGS32 NRD2 BYPASS0
//   inst2: XLEN64 NREGS16 NRD3 BYPASS1   inst3: XLEN64 NREGS32 NRD3 BYPASS0
module tb_rv_regfile_sb;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        sys_reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [14:0] rs_addr;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  rv_regfile_sb_if #(.XLEN(32), .NRD(2)) if0 ();
  rv_regfile_sb_if #(.XLEN(32), .NRD(2)) if1 ();
  rv_regfile_sb_if #(.XLEN(64), .NRD(3)) if2 ();
  rv_regfile_sb_if #(.XLEN(64), .NRD(3)) if3 ();

  assign if0.rs_addr = rs_addr[9:0];
  assign if1.rs_addr = rs_addr[9:0];
  assign if2.rs_addr = rs_addr;
  assign if3.rs_addr = rs_addr;
  assign if0.wb_data = wb_data[31:0];
  assign if1.wb_data = wb_data[31:0];
  assign if2.wb_data = wb_data;
  assign if3.wb_data = wb_data;
  assign {if0.wb_we, if1.wb_we, if2.wb_we, if3.wb_we} = {4{wb_we}};
  assign {if0.wb_addr, if1.wb_addr, if2.wb_addr, if3.wb_addr} = {4{wb_addr}};
  assign {if0.alloc_en, if1.alloc_en, if2.alloc_en, if3.alloc_en} = {4{alloc_en}};
  assign {if0.alloc_addr, if1.alloc_addr, if2.alloc_addr, if3.alloc_addr} = {4{alloc_addr}};

  rv_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut0 (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .bus(if0));
  rv_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut1 (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .bus(if1));
  rv_regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(1)) dut2 (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .bus(if2));
  rv_regfile_sb #(.XLEN(64), .NREGS(32), .NRD(3), .BYPASS(0)) dut3 (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .bus(if3));

  // Uniform view of DUT outputs.
  logic [63:0] act_data [4][3];
  logic        act_busy [4][3];
  logic        act_ill  [4][3];
  logic        act_aok  [4];
  logic        act_any  [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        act_data[i][k] = '0;
        act_busy[i][k] = 1'b0;
        act_ill[i][k]  = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      act_data[0][k] = {32'b0, if0.rs_data[32*k +: 32]};
      act_busy[0][k] = if0.rs_busy[k];
      act_ill[0][k]  = if0.rs_illegal[k];
      act_data[1][k] = {32'b0, if1.rs_data[32*k +: 32]};
      act_busy[1][k] = if1.rs_busy[k];
      act_ill[1][k]  = if1.rs_illegal[k];
    end
    for (int k = 0; k < 3; k++) begin
      act_data[2][k] = if2.rs_data[64*k +: 64];
      act_busy[2][k] = if2.rs_busy[k];
      act_ill[2][k]  = if2.rs_illegal[k];
      act_data[3][k] = if3.rs_data[64*k +: 64];
      act_busy[3][k] = if3.rs_busy[k];
      act_ill[3][k]  = if3.rs_illegal[k];
    end
  end

  assign act_aok[0] = if0.alloc_ok;
  assign act_aok[1] = if1.alloc_ok;
  assign act_aok[2] = if2.alloc_ok;
  assign act_aok[3] = if3.alloc_ok;
  assign act_any[0] = if0.any_busy;
  assign act_any[1] = if1.any_busy;
  assign act_any[2] = if2.any_busy;
  assign act_any[3] = if3.any_busy;

  // ---------------- reference model ----------------
  function automatic int xl(int i); return (i >= 2) ? 64 : 32; endfunction
  function automatic int nr(int i); return (i == 2) ? 16 : 32; endfunction
  function automatic int nd(int i); return (i >= 2) ? 3 : 2;   endfunction
  function automatic int bp(int i); return (i % 2 == 0) ? 1 : 0; endfunction

  logic [63:0] mreg  [4][32];
  bit          mbusy [4][32];

  function automatic logic [63:0] mask(int i, logic [63:0] v);
    return (xl(i) == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  function automatic bit in_range(int i, logic [4:0] a);
    return int'(a) < nr(i);
  endfunction

  // Same-cycle writeback visible to readers/allocator of register a.
  function automatic bit wb_rel(int i, logic [4:0] a);
    return bp(i) == 1 && sys_reset && wb_we && wb_addr == a && a != 5'd0 &&
           in_range(i, a);
  endfunction

  function automatic logic [63:0] exp_data(int i, int k);
    logic [4:0] a;
    a = rs_addr[5*k +: 5];
    if (!in_range(i, a) || a == 5'd0) return '0;
    if (wb_rel(i, a)) return mask(i, wb_data);
    return mreg[i][a];
  endfunction

  function automatic bit exp_busy(int i, int k);
    logic [4:0] a;
    a = rs_addr[5*k +: 5];
    if (!in_range(i, a) || a == 5'd0) return 1'b0;
    if (wb_rel(i, a)) return 1'b0;
    return mbusy[i][a];
  endfunction

  function automatic bit exp_aok(int i);
    if (!in_range(i, alloc_addr)) return 1'b0;
    if (alloc_addr == 5'd0) return 1'b1;
    return !mbusy[i][alloc_addr] || wb_rel(i, alloc_addr);
  endfunction

  function automatic bit exp_any(int i);
    bit b;
    b = 1'b0;
    for (int r = 0; r < 32; r++) b |= mbusy[i][r];
    return b;
  endfunction

  task automatic model_step();
    bit aok;
    for (int i = 0; i < 4; i++) begin
      if (!sys_reset) begin
        for (int r = 0; r < 32; r++) begin
          mreg[i][r]  = '0;
          mbusy[i][r] = 1'b0;
        end
      end else begin
        aok = exp_aok(i);
        if (wb_we && in_range(i, wb_addr) && wb_addr != 5'd0) begin
          mreg[i][wb_addr]  = mask(i, wb_data);
          mbusy[i][wb_addr] = 1'b0;
        end
        if (alloc_en && aok && alloc_addr != 5'd0) mbusy[i][alloc_addr] = 1'b1;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic cmp(string nm, int i, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h required=%h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < nd(i); k++) begin
          cmp($sformatf("rs_data[%0d]", k), i, act_data[i][k], exp_data(i, k));
          cmp($sformatf("rs_busy[%0d]", k), i, 64'(act_busy[i][k]), 64'(exp_busy(i, k)));
          cmp($sformatf("rs_illegal[%0d]", k), i, 64'(act_ill[i][k]),
              64'(!in_range(i, rs_addr[5*k +: 5])));
        end
        cmp("any_busy", i, 64'(act_any[i]), 64'(exp_any(i)));
        if (sys_reset) cmp("alloc_ok", i, 64'(act_aok[i]), 64'(exp_aok(i)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_idle();
    sys_reset = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rs_addr = '0;
  endtask

  task automatic set_rs(int k, logic [4:0] a);
    rs_addr[5*k +: 5] = a;
  endtask

  task automatic settle();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clk_edge();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(0, 20));
  endfunction

  initial begin
    set_idle();
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 32; r++) begin
        mreg[i][r] = '0; mbusy[i][r] = 1'b0;
      end

    // initial reset, two cycles
    sys_reset = 1'b0;
    @(posedge sys_clk); model_step(); #1;
    chk_en = 1'b1;
    clk_edge();
    sys_reset = 1'b1;

    // fill x1..x31 with pattern, reserving each as it is written
    for (int r = 1; r < 32; r++) begin
      wb_we = 1'b1; wb_addr = 5'(r); wb_data = 64'hA5A5A5A5A5A5A5A5;
      alloc_en = 1'b1; alloc_addr = 5'(r);
      settle(); clk_edge();
    end
    wb_we = 1'b0; alloc_en = 1'b0; set_rs(0, 5'd1);
    settle();
    cmp("fill_x1", 0, act_data[0][0], 64'hA5A5A5A5);
    cmp("fill_any", 0, 64'(act_any[0]), 64'd1);
    clk_edge();

    // reset held two cycles, competing with write and alloc
    sys_reset = 1'b0; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 64'h1234;
    alloc_en = 1'b1; alloc_addr = 5'd2; set_rs(0, 5'd3); set_rs(1, 5'd1);
    settle(); clk_edge();
    settle();
    cmp("rst_data", 0, act_data[0][0], 64'd0);
    cmp("rst_data64", 2, act_data[2][1], 64'd0);
    cmp("rst_any", 1, 64'(act_any[1]), 64'd0);
    clk_edge();
    sys_reset = 1'b1; wb_we = 1'b0; alloc_en = 1'b0;

    // x0 write ignored
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = '1; set_rs(0, 5'd0);
    settle(); cmp("x0_same", 0, act_data[0][0], 64'd0); clk_edge();
    wb_we = 1'b0;
    settle(); cmp("x0_after", 2, act_data[2][0], 64'd0); clk_edge();

    // bypass vs stored-only read
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 64'h12345678; set_rs(0, 5'd5);
    settle();
    cmp("byp1_same", 0, act_data[0][0], 64'h12345678);
    cmp("byp0_old", 1, act_data[1][0], 64'd0);
    clk_edge();
    wb_we = 1'b0;
    settle(); cmp("byp0_next", 1, act_data[1][0], 64'h12345678); clk_edge();

    // alloc x7, second alloc rejected, then writeback releases
    alloc_en = 1'b1; alloc_addr = 5'd7; set_rs(1, 5'd7);
    settle(); cmp("aok_x7_first", 0, 64'(act_aok[0]), 64'd1); clk_edge();
    settle();
    cmp("busy_x7", 0, 64'(act_busy[0][1]), 64'd1);
    cmp("aok_x7_again", 0, 64'(act_aok[0]), 64'd0);
    cmp("any_x7", 0, 64'(act_any[0]), 64'd1);
    clk_edge();
    alloc_en = 1'b0; wb_we = 1'b1; wb_addr = 5'd7; wb_data = 64'hDEAD0007;
    settle();
    cmp("busy_x7_byp", 0, 64'(act_busy[0][1]), 64'd0);
    cmp("busy_x7_nobyp", 1, 64'(act_busy[1][1]), 64'd1);
    clk_edge();
    wb_we = 1'b0;
    settle();
    cmp("x7_data", 0, act_data[0][1], 64'hDEAD0007);
    cmp("x7_busy_clr", 1, 64'(act_busy[1][1]), 64'd0);
    cmp("x7_any", 0, 64'(act_any[0]), 64'd0);
    clk_edge();

    // same-cycle wb and alloc on a busy register
    alloc_en = 1'b1; alloc_addr = 5'd9;
    settle(); clk_edge();
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 64'h99; set_rs(0, 5'd9);
    settle();
    cmp("x9_aok_byp", 0, 64'(act_aok[0]), 64'd1);
    cmp("x9_aok_nobyp", 1, 64'(act_aok[1]), 64'd0);
    clk_edge();
    wb_we = 1'b0; alloc_en = 1'b0;
    settle();
    cmp("x9_data", 0, act_data[0][0], 64'h99);
    cmp("x9_busy_byp", 0, 64'(act_busy[0][0]), 64'd1);
    cmp("x9_data_nobyp", 1, act_data[1][0], 64'h99);
    cmp("x9_busy_nobyp", 1, 64'(act_busy[1][0]), 64'd0);
    clk_edge();

    // out-of-range accesses on the 16-register instance
    set_rs(0, 5'd20); alloc_en = 1'b1; alloc_addr = 5'd16;
    wb_we = 1'b1; wb_addr = 5'd17; wb_data = 64'h17;
    settle();
    cmp("ill_flag", 2, 64'(act_ill[2][0]), 64'd1);
    cmp("ill_data", 2, act_data[2][0], 64'd0);
    cmp("ill_aok", 2, 64'(act_aok[2]), 64'd0);
    cmp("legal_flag32", 0, 64'(act_ill[0][0]), 64'd0);
    clk_edge();
    wb_we = 1'b0; alloc_en = 1'b0; set_rs(0, 5'd17);
    settle(); cmp("x17_32reg", 0, act_data[0][0], 64'h17); clk_edge();

    // 64-bit write to x31 seen on all three ports
    wb_we = 1'b1; wb_addr = 5'd31; wb_data = 64'hFEDCBA9876543210;
    set_rs(0, 5'd31); set_rs(1, 5'd31); set_rs(2, 5'd31);
    settle(); cmp("x31_old", 3, act_data[3][2], 64'd0); clk_edge();
    wb_we = 1'b0;
    settle();
    for (int k = 0; k < 3; k++)
      cmp($sformatf("x31_port%0d", k), 3, act_data[3][k], 64'hFEDCBA9876543210);
    cmp("x31_low32", 0, act_data[0][1], 64'h76543210);
    cmp("x31_ill16", 2, 64'(act_ill[2][2]), 64'd1);
    clk_edge();

    // reset clears a pending reservation
    alloc_en = 1'b1; alloc_addr = 5'd4; set_rs(0, 5'd4);
    settle(); clk_edge();
    alloc_en = 1'b0;
    settle(); cmp("x4_busy", 3, 64'(act_busy[3][0]), 64'd1); clk_edge();
    sys_reset = 1'b0;
    settle(); clk_edge();
    settle();
    cmp("x4_busy_rst", 3, 64'(act_busy[3][0]), 64'd0);
    cmp("any_rst", 3, 64'(act_any[3]), 64'd0);
    clk_edge();
    sys_reset = 1'b1;

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      sys_reset  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      wb_we      = 1'($urandom_range(0, 1));
      wb_addr    = rand_addr();
      wb_data    = {$urandom, $urandom};
      alloc_en   = 1'($urandom_range(0, 1));
      alloc_addr = ($urandom_range(0, 4) == 0) ? wb_addr : rand_addr();
      for (int k = 0; k < 3; k++)
        set_rs(k, ($urandom_range(0, 3) == 0) ? wb_addr : rand_addr());
      settle();
      clk_edge();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_regfile_sb.md
Name: rv_regfile_sb

Overview:
Parametrised next-generation integer register file for the RV core family. It covers RV32I/RV64I (XLEN) and RV32E (16 registers), with a configurable number of read ports. It adds an optional write-to-read bypass and a per-register busy scoreboard, so a pipelined issue stage can detect RAW hazards. It sits between decode/issue (reads, allocation) and writeback (writes, busy release).

Parameters:
XLEN, 32, register width in bits (32 or 64)
NREGS, 32, architectural register count (32 or 16); x0 always included
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only

Ports:
sys_clk  in  1  clock; all state updates on rising edge
sys_reset  in  1  reset, synchronous, active-low (sampled on rising sys_clk; 0 = reset)
rs_addr  in  5*NRD  read addresses; port k uses bits [5k+4:5k]
rs_data  out  XLEN*NRD  read data, port k in [XLEN*k+XLEN-1:XLEN*k]
rs_busy  out  NRD  port k source has a pending write (scoreboard bit, after bypass rule)
rs_illegal  out  NRD  port k address >= NREGS
wb_we  in  1  writeback enable
wb_addr  in  5  writeback destination
wb_data  in  XLEN  writeback data
alloc_en  in  1  issue stage reserves a destination
alloc_addr  in  5  destination being reserved
alloc_ok  out  1  alloc_addr legal and not already busy (combinational)
any_busy  out  1  OR of all busy bits (drain indicator)

Behaviour:
- Reset (sys_reset==0 at a rising edge): registers 1..NREGS-1 <= 0; all busy bits <= 0. Reset has priority over wb_we and alloc_en in the same cycle. While reset is held, rs_data reads 0 and any_busy=0 from the cycle after the first reset edge.
- x0: reads always 0; writes ignored; never busy; alloc to x0 is accepted (alloc_ok=1) with no state change.
- Reads are combinational, zero latency.
- Out-of-range address (>= NREGS):
  - read: rs_data=0, rs_busy=0, rs_illegal=1.
  - write: ignored.
  - alloc: alloc_ok=0, no state change.
- Write: on a rising edge with wb_we=1 and a legal nonzero wb_addr, reg[wb_addr] <= wb_data and busy[wb_addr] <= 0.
- Bypass:
  - BYPASS=1: when wb_we=1 and rs_addr[k]==wb_addr (nonzero, legal), rs_data[k]=wb_data and rs_busy[k]=0 in the same cycle.
  - BYPASS=0: rs_data and rs_busy reflect stored state only.
- Allocation: on a rising edge with alloc_en=1, alloc_ok=1 and nonzero alloc_addr, busy[alloc_addr] <= 1. alloc_en with alloc_ok=0 has no effect; the issuer must stall and retry.
- Simultaneous wb and alloc to the same register:
  - write data is stored;
  - busy ends at 1, because the new producer wins;
  - alloc_ok evaluates with the write's release applied (BYPASS=1) or without it (BYPASS=0).
- Simultaneous wb and alloc to different registers: both take effect.
- Busy state per register: IDLE -(alloc)-> BUSY -(wb)-> IDLE; BUSY+alloc is rejected.
- Write with busy=0 (unscoreboarded producer) is legal and just writes.
- any_busy is registered-state based and excludes same-cycle events.
- Width: all data paths are XLEN bits; no sign or zero extension inside the block.

Test Plan:
1. Hold sys_reset=0 two cycles after filling x1..x31 with 0xA5A5A5A5 -> all reads 0, any_busy=0; x0 write of 0xFFFFFFFF -> rs_data stays 0.
2. wb_we=1, wb_addr=5, wb_data=0x12345678, rs_addr[0]=5, BYPASS=1 -> rs_data[0]=0x12345678 in the same cycle. Repeat with BYPASS=0 -> old value in the same cycle, new value next cycle.
3. alloc x7 -> rs_busy=1 on the port reading x7 and alloc_ok=0 for a second alloc of x7. Then wb x7=0xDEAD0007 -> busy clears, value read back, any_busy=0.
4. Same-cycle wb x9=0x99 and alloc x9 (x9 busy beforehand) -> x9=0x99, busy[9]=1 after the edge; with BYPASS=1 alloc_ok=1.
5. NREGS=16, rs_addr=20, alloc_addr=16, wb_addr=17 -> rs_illegal=1, rs_data=0, alloc_ok=0, no register changes.
6. XLEN=64, NRD=3: write 0xFEDCBA9876543210 to x31 -> all three ports reading x31 return the full 64-bit value; sys_reset=0 during a pending alloc -> busy cleared after that edge.
